// File: rtl/filter_window_sequencer.sv
// filter_window_sequencer
// Walks a frame pixel by pixel. For each pixel it reads the 3x3 neighbourhood
// (edge-replicated at the borders) from source memory, holds the packed window
// steady while the filter works, then writes the filter result to destination
// memory. Control outputs are registered: the next-state logic also computes
// the output values for the coming cycle.
module filter_window_sequencer #(
  parameter int IMG_W      = 160,
  parameter int IMG_H      = 120,
  parameter int ADDR_W     = 15,
  parameter int FILTER_LAT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [11:0]       rd_data,
  output logic [107:0]      win_data,
  output logic              win_valid,
  input  logic [11:0]       filt_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [11:0]       wr_data
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int CW = (FILTER_LAT > 1) ? $clog2(FILTER_LAT) : 1;

  localparam logic [XW-1:0] X_MAX     = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_MAX     = YW'(IMG_H - 1);
  localparam logic [CW-1:0] WAIT_INIT = CW'(FILTER_LAT - 1);
  localparam logic [3:0]    K_LAST    = 4'd9;
  localparam logic [3:0]    K_LAST_RD = 4'd8;

  // Neighbour offset codes
  localparam logic [1:0] D_ZERO  = 2'd0;
  localparam logic [1:0] D_MINUS = 2'd1;
  localparam logic [1:0] D_PLUS  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Horizontal offset of neighbour k in the order
  // centre, left, right, up, down, upleft, upright, downleft, downright.
  function automatic logic [1:0] dx_of(input logic [3:0] k);
    logic [1:0] d;
    case (k)
      4'd1, 4'd5, 4'd7: d = D_MINUS;
      4'd2, 4'd6, 4'd8: d = D_PLUS;
      default:          d = D_ZERO;
    endcase
    return d;
  endfunction

  // Vertical offset of neighbour k (same ordering as dx_of).
  function automatic logic [1:0] dy_of(input logic [3:0] k);
    logic [1:0] d;
    case (k)
      4'd3, 4'd5, 4'd6: d = D_MINUS;
      4'd4, 4'd7, 4'd8: d = D_PLUS;
      default:          d = D_ZERO;
    endcase
    return d;
  endfunction

  // Clamped step along x; equivalent to min(max(x+dx,0),IMG_W-1) for |dx|<=1,
  // written as compares so the coordinate can never leave the frame.
  function automatic logic [XW-1:0] step_x(input logic [XW-1:0] x, input logic [1:0] d);
    logic [XW-1:0] r;
    case (d)
      D_MINUS: r = (x == {XW{1'b0}}) ? x : (x - XW'(1));
      D_PLUS:  r = (x == X_MAX) ? x : (x + XW'(1));
      default: r = x;
    endcase
    return r;
  endfunction

  // Clamped step along y; see step_x.
  function automatic logic [YW-1:0] step_y(input logic [YW-1:0] y, input logic [1:0] d);
    logic [YW-1:0] r;
    case (d)
      D_MINUS: r = (y == {YW{1'b0}}) ? y : (y - YW'(1));
      D_PLUS:  r = (y == Y_MAX) ? y : (y + YW'(1));
      default: r = y;
    endcase
    return r;
  endfunction

  // Linear pixel address y*IMG_W + x in ADDR_W-bit unsigned arithmetic.
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return ADDR_W'(y) * ADDR_W'(IMG_W) + ADDR_W'(x);
  endfunction

  state_t              state_r, state_s;
  logic [3:0]          k_r, k_s;
  logic [XW-1:0]       x_r, x_s;
  logic [YW-1:0]       y_r, y_s;
  logic [CW-1:0]       wcnt_r, wcnt_s;
  logic [107:0]        win_r, win_s;
  logic                busy_s, done_s, rd_en_s, win_valid_s, wr_en_s;
  logic [ADDR_W-1:0]   rd_addr_s, wr_addr_s;

  assign win_data = win_r;
  // The filter result is only valid during WRITE, so it is passed straight
  // through and forced to zero at all other times.
  assign wr_data  = (state_r == ST_WRITE) ? filt_data : 12'd0;

  // Next-state, counter, window-capture and next-output computation.
  always_comb begin
    state_s = state_r;
    k_s     = k_r;
    x_s     = x_r;
    y_s     = y_r;
    wcnt_s  = wcnt_r;
    win_s   = win_r;

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_FETCH;
          k_s     = 4'd0;
          x_s     = {XW{1'b0}};
          y_s     = {YW{1'b0}};
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (k_r == K_LAST) begin
          state_s = ST_WAIT;
          k_s     = 4'd0;
          wcnt_s  = WAIT_INIT;
        end else begin
          k_s = k_r + 4'd1;
        end
      end
      ST_WAIT: begin
        if (wcnt_r == {CW{1'b0}}) begin
          state_s = ST_WRITE;
        end else begin
          wcnt_s = wcnt_r - CW'(1);
        end
      end
      ST_WRITE: begin
        if ((x_r == X_MAX) && (y_r == Y_MAX)) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_FETCH;
          k_s     = 4'd0;
          if (x_r == X_MAX) begin
            x_s = {XW{1'b0}};
            y_s = y_r + YW'(1);
          end else begin
            x_s = x_r + XW'(1);
          end
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // Read data trails its strobe by one cycle: during FETCH step k the bus
    // carries neighbour k-1.
    if (state_r == ST_FETCH) begin
      case (k_r)
        4'd1:    win_s[107:96] = rd_data;
        4'd2:    win_s[95:84]  = rd_data;
        4'd3:    win_s[83:72]  = rd_data;
        4'd4:    win_s[71:60]  = rd_data;
        4'd5:    win_s[59:48]  = rd_data;
        4'd6:    win_s[47:36]  = rd_data;
        4'd7:    win_s[35:24]  = rd_data;
        4'd8:    win_s[23:12]  = rd_data;
        4'd9:    win_s[11:0]   = rd_data;
        default: win_s         = win_r;
      endcase
    end else begin
      win_s = win_r;
    end

    // Output values for the coming cycle, derived from the next state.
    busy_s      = (state_s == ST_FETCH) || (state_s == ST_WAIT) || (state_s == ST_WRITE);
    done_s      = (state_s == ST_DONE);
    rd_en_s     = (state_s == ST_FETCH) && (k_s <= K_LAST_RD);
    win_valid_s = (state_s == ST_WAIT) || (state_s == ST_WRITE);
    wr_en_s     = (state_s == ST_WRITE);

    if (rd_en_s) begin
      rd_addr_s = pix_addr(step_x(x_s, dx_of(k_s)), step_y(y_s, dy_of(k_s)));
    end else begin
      rd_addr_s = rd_addr;
    end

    if (wr_en_s) begin
      wr_addr_s = pix_addr(x_s, y_s);
    end else begin
      wr_addr_s = wr_addr;
    end
  end

  // State, counters, window and registered outputs; reset aborts any pass.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      k_r       <= 4'd0;
      x_r       <= {XW{1'b0}};
      y_r       <= {YW{1'b0}};
      wcnt_r    <= {CW{1'b0}};
      win_r     <= 108'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr   <= {ADDR_W{1'b0}};
      win_valid <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= {ADDR_W{1'b0}};
    end else begin
      state_r   <= state_s;
      k_r       <= k_s;
      x_r       <= x_s;
      y_r       <= y_s;
      wcnt_r    <= wcnt_s;
      win_r     <= win_s;
      busy      <= busy_s;
      done      <= done_s;
      rd_en     <= rd_en_s;
      rd_addr   <= rd_addr_s;
      win_valid <= win_valid_s;
      wr_en     <= wr_en_s;
      wr_addr   <= wr_addr_s;
    end
  end

endmodule

// File: tb/tb_filter_window_sequencer.sv
// tb_filter_window_sequencer
// Directed bench on a 4x3 frame with FILTER_LAT=3. Source memory returns the
// pixel's own address as data; the filter input changes every cycle so the
// write path must forward it in the WRITE cycle itself.
module tb_filter_window_sequencer;

  localparam int IMG_W  = 4;
  localparam int IMG_H  = 3;
  localparam int ADDR_W = 4;
  localparam int LAT    = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              busy, done, rd_en, win_valid, wr_en;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [11:0]       rd_data = 12'hEEE;
  logic [11:0]       filt_data = 12'h000;
  logic [107:0]      win_data;
  logic [11:0]       wr_data;

  int vectors = 0;
  int miscompares = 0;

  int edges, done_cnt, done_edge, activity, run_len, unstable;
  logic [107:0]      win_hold;
  logic [ADDR_W-1:0] rd_log[$];
  logic [ADDR_W-1:0] wr_log[$];
  logic [107:0]      win_log[$];
  int                runs[$];

  filter_window_sequencer #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .FILTER_LAT(LAT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .win_data(win_data), .win_valid(win_valid), .filt_data(filt_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Source memory: pixel[a] = a, one-cycle read latency, junk when idle.
  always @(posedge clk) rd_data <= rd_en ? {8'h00, rd_addr} : 12'hEEE;

  // Filter output stand-in: a value that changes every cycle.
  always @(posedge clk) filt_data <= filt_data + 12'h025;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".busy"},      busy,      1'b0);
    chk({tag, ".done"},      done,      1'b0);
    chk({tag, ".rd_en"},     rd_en,     1'b0);
    chk({tag, ".rd_addr"},   rd_addr,   4'd0);
    chk({tag, ".win_data"},  win_data,  108'd0);
    chk({tag, ".win_valid"}, win_valid, 1'b0);
    chk({tag, ".wr_en"},     wr_en,     1'b0);
    chk({tag, ".wr_addr"},   wr_addr,   4'd0);
    chk({tag, ".wr_data"},   wr_data,   12'd0);
  endtask

  // Record one cycle of DUT activity (called at the negedge).
  task automatic observe();
    if (rd_en) rd_log.push_back(rd_addr);
    if (wr_en) begin
      wr_log.push_back(wr_addr);
      chk("wr_data", wr_data, filt_data);
    end
    if (done) begin
      done_cnt++;
      if (done_edge < 0) done_edge = edges;
      chk("busy_at_done", busy, 1'b0);
    end
    if (win_valid) begin
      if (run_len == 0) begin
        win_hold = win_data;
        win_log.push_back(win_data);
      end else if (win_data !== win_hold) begin
        unstable++;
      end
      run_len++;
    end else if (run_len != 0) begin
      runs.push_back(run_len);
      run_len = 0;
    end
  endtask

  // One frame pass of 'cycles' edges after start is accepted, with an optional
  // start pulse while busy and an optional reset sampled at reset_edge.
  task automatic run_pass(input int cycles, input int pulse_edge, input int reset_edge);
    rd_log.delete(); wr_log.delete(); win_log.delete(); runs.delete();
    done_cnt = 0; done_edge = -1; activity = 0; run_len = 0; unstable = 0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    edges = 0;
    chk("busy_after_start", busy, 1'b1);
    observe();
    while (edges < cycles) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      observe();
      if (reset_edge > 0 && edges == reset_edge) begin
        chk_idle("mid_reset");
        reset = 1'b0;
      end
      if (reset_edge > 0 && edges >= reset_edge && (busy || rd_en || wr_en || done || win_valid))
        activity++;
      if (reset_edge > 0 && edges == reset_edge - 1) reset = 1'b1;
      start = (edges == pulse_edge);
    end
    start = 1'b0;
  endtask

  function automatic logic [35:0] pack_rd(input int base);
    logic [35:0] r = 36'd0;
    for (int i = 0; i < 9; i++) begin
      if (base + i < rd_log.size()) r = {r[31:0], rd_log[base + i]};
      else r = {r[31:0], 4'hF};
    end
    return r;
  endfunction

  // Main directed sequence.
  initial begin
    int bad;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle("por");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_no_start.busy", busy, 1'b0);

    // Full frame pass.
    run_pass(175, -1, -1);
    chk("p1.writes", wr_log.size(), 12);
    for (int i = 0; i < 12; i++)
      if (i < wr_log.size()) chk($sformatf("p1.wr_addr[%0d]", i), wr_log[i], i);
    chk("p1.done_cnt", done_cnt, 1);
    chk("p1.done_edge", done_edge, 168);
    chk("p1.reads", rd_log.size(), 108);
    chk("p1.rd_px0", pack_rd(0),
        {4'd0, 4'd0, 4'd1, 4'd0, 4'd4, 4'd0, 4'd1, 4'd4, 4'd5});
    chk("p1.rd_px5", pack_rd(45),
        {4'd5, 4'd4, 4'd6, 4'd1, 4'd9, 4'd0, 4'd2, 4'd8, 4'd10});
    chk("p1.rd_px11", pack_rd(99),
        {4'd11, 4'd10, 4'd11, 4'd7, 4'd11, 4'd6, 4'd7, 4'd10, 4'd11});
    chk("p1.windows", win_log.size(), 12);
    if (win_log.size() == 12) begin
      chk("p1.win_px0", win_log[0],
          {12'd0, 12'd0, 12'd1, 12'd0, 12'd4, 12'd0, 12'd1, 12'd4, 12'd5});
      chk("p1.win_px5", win_log[5],
          {12'd5, 12'd4, 12'd6, 12'd1, 12'd9, 12'd0, 12'd2, 12'd8, 12'd10});
      chk("p1.win_px11", win_log[11],
          {12'd11, 12'd10, 12'd11, 12'd7, 12'd11, 12'd6, 12'd7, 12'd10, 12'd11});
    end
    chk("p1.valid_runs", runs.size(), 12);
    bad = 0;
    foreach (runs[i]) if (runs[i] != LAT + 1) bad++;
    chk("p1.valid_len_bad", bad, 0);
    chk("p1.win_unstable", unstable, 0);

    // start pulsed while busy must be ignored.
    run_pass(175, 50, -1);
    chk("p2.writes", wr_log.size(), 12);
    chk("p2.done_cnt", done_cnt, 1);
    chk("p2.done_edge", done_edge, 168);
    chk("p2.busy_after", busy, 1'b0);

    // Reset during the WAIT phase of pixel 6 aborts the pass.
    run_pass(110, -1, 96);
    chk("p3.writes", wr_log.size(), 6);
    if (wr_log.size() > 0) chk("p3.last_wr", wr_log[wr_log.size() - 1], 4'd5);
    chk("p3.done_cnt", done_cnt, 0);
    chk("p3.activity", activity, 0);

    // Fresh pass after the abort starts again from address 0.
    run_pass(175, -1, -1);
    chk("p4.writes", wr_log.size(), 12);
    if (wr_log.size() > 0) chk("p4.first_wr", wr_log[0], 4'd0);
    chk("p4.done_edge", done_edge, 168);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
